odu_chid_scheduler: RTL and testbench

Round-robin read scheduler for the per-channel ODU generator FIFOs. Watches the 80 FIFO empty flags, the channel enable and type masks, and the global start, then issues at most one FIFO read per cycle. It muxes the returned FIFO word onto a single output stream tagged with its channel ID. It sits between the configuration block (`odu_ctr_data`) and the 80 `odu_count_gen_fifo` instances, in place of a free-running selector.

---
 rtl/odu_chid_scheduler.sv | 179 +++++++++++++++++
 tb/tb_odu_chid_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odu_chid_scheduler.sv
// rtl/odu_chid_scheduler.sv - round-robin read scheduler for the per-channel ODU generator FIFOs
// Optional two-level priority build: define ODU_SCHED_PRIO_EN (uses type_chid, separate hi/lo pointers).
module odu_chid_scheduler #(
   parameter int N_CH   = 80,
   parameter int DATA_W = 387,
   parameter int CHID_W = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [N_CH-1:0]          enable_chid,
   input  logic [N_CH-1:0]          type_chid,
   input  logic [N_CH-1:0]          fifo_empty,
   input  logic [N_CH*DATA_W-1:0]   fifo_data,
   output logic [N_CH-1:0]          fifo_read_enable,
   output logic [DATA_W-1:0]        data_out,
   output logic                     data_valid,
   output logic [CHID_W-1:0]        chid_out,
   output logic                     busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [N_CH-1:0]     fifo_read_enable_q, fifo_read_enable_d;
   logic                rd_q, rd_d;
   logic [CHID_W-1:0]   sel_q, sel_d;
   logic                cap_valid_q, cap_valid_d;
   logic [DATA_W-1:0]   cap_data_q, cap_data_d;
   logic [CHID_W-1:0]   cap_chid_q, cap_chid_d;
   logic                data_valid_q, data_valid_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic [CHID_W-1:0]   chid_out_q, chid_out_d;
   logic                busy_q, busy_d;
`ifdef ODU_SCHED_PRIO_EN
   logic [CHID_W-1:0]   ptr_hi_q, ptr_hi_d;
   logic [CHID_W-1:0]   ptr_lo_q, ptr_lo_d;
   logic [N_CH-1:0]     req_hi, req_lo;
`else
   logic [CHID_W-1:0]   ptr_q, ptr_d;
   logic                type_unused;
   assign type_unused = ^type_chid;
`endif

   logic [N_CH-1:0]     req;
   logic [CHID_W:0]     pick;
   logic                grant;
   logic [CHID_W-1:0]   win;
   logic [DATA_W-1:0]   fifo_word;

   // Returns {found, index} of the first set bit at or circularly after p.
   function automatic logic [CHID_W:0] rr_pick(input logic [N_CH-1:0] r, input logic [CHID_W-1:0] p);
      logic [CHID_W:0] res;
      int              best_d;
      int              d;
      res    = '0;
      best_d = N_CH;
      for (int j = 0; j < N_CH; j++) begin
         if (r[j]) begin
            d = (j >= int'(p)) ? j - int'(p) : j + N_CH - int'(p);
            if (d < best_d) begin
               best_d = d;
               res    = {1'b1, CHID_W'(j)};
            end
         end
      end
      return res;
   endfunction

   function automatic logic [CHID_W-1:0] ptr_after(input logic [CHID_W-1:0] w);
      return (w == CHID_W'(N_CH-1)) ? '0 : w + 1'b1;
   endfunction

   always_comb begin
      fifo_word = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_q == CHID_W'(i)) fifo_word = fifo_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      // The strobe register doubles as the lock: a FIFO's empty flag trails its read by one cycle.
      req = {N_CH{start}} & enable_chid & ~fifo_empty & ~fifo_read_enable_q;

`ifdef ODU_SCHED_PRIO_EN
      req_hi   = req & type_chid;
      req_lo   = req & ~type_chid;
      ptr_hi_d = ptr_hi_q;
      ptr_lo_d = ptr_lo_q;
      if (|req_hi) begin
         pick = rr_pick(req_hi, ptr_hi_q);
         if (pick[CHID_W]) ptr_hi_d = ptr_after(pick[CHID_W-1:0]);
      end else begin
         pick = rr_pick(req_lo, ptr_lo_q);
         if (pick[CHID_W]) ptr_lo_d = ptr_after(pick[CHID_W-1:0]);
      end
`else
      ptr_d = ptr_q;
      pick  = rr_pick(req, ptr_q);
      if (pick[CHID_W]) ptr_d = ptr_after(pick[CHID_W-1:0]);
`endif
      grant = pick[CHID_W];
      win   = pick[CHID_W-1:0];

      for (int j = 0; j < N_CH; j++) begin
         fifo_read_enable_d[j] = grant && (win == CHID_W'(j));
      end
      rd_d  = grant;
      sel_d = grant ? win : sel_q;

      cap_valid_d = rd_q;
      cap_data_d  = rd_q ? fifo_word : cap_data_q;
      cap_chid_d  = rd_q ? sel_q : cap_chid_q;

      data_valid_d = cap_valid_q;
      data_out_d   = cap_valid_q ? cap_data_q : data_out_q;
      chid_out_d   = cap_valid_q ? cap_chid_q : chid_out_q;

      // start gates req directly, so DRAIN/IDLE never grant; the FSM only tracks pipeline occupancy.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (!start) state_d = S_DRAIN;
         S_DRAIN: begin
            if (start)                       state_d = S_RUN;
            else if (!rd_q && !cap_valid_q)  state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q            <= S_IDLE;
         fifo_read_enable_q <= '0;
         rd_q               <= 1'b0;
         sel_q              <= '0;
         cap_valid_q        <= 1'b0;
         cap_data_q         <= '0;
         cap_chid_q         <= '0;
         data_valid_q       <= 1'b0;
         data_out_q         <= '0;
         chid_out_q         <= '0;
         busy_q             <= 1'b0;
`ifdef ODU_SCHED_PRIO_EN
         ptr_hi_q           <= '0;
         ptr_lo_q           <= '0;
`else
         ptr_q              <= '0;
`endif
      end else begin
         state_q            <= state_d;
         fifo_read_enable_q <= fifo_read_enable_d;
         rd_q               <= rd_d;
         sel_q              <= sel_d;
         cap_valid_q        <= cap_valid_d;
         cap_data_q         <= cap_data_d;
         cap_chid_q         <= cap_chid_d;
         data_valid_q       <= data_valid_d;
         data_out_q         <= data_out_d;
         chid_out_q         <= chid_out_d;
         busy_q             <= busy_d;
`ifdef ODU_SCHED_PRIO_EN
         ptr_hi_q           <= ptr_hi_d;
         ptr_lo_q           <= ptr_lo_d;
`else
         ptr_q              <= ptr_d;
`endif
      end
   end

   assign fifo_read_enable = fifo_read_enable_q;
   assign data_out         = data_out_q;
   assign data_valid       = data_valid_q;
   assign chid_out         = chid_out_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_odu_chid_scheduler.sv
// tb/tb_odu_chid_scheduler.sv - scoreboard bench for odu_chid_scheduler
// Priority scenario runs only when ODU_SCHED_PRIO_EN is defined.
module tb_odu_chid_scheduler;
   localparam int N_CH   = 80;
   localparam int DATA_W = 387;
   localparam int CHID_W = 7;

   logic                   clk;
   logic                   rst;
   logic                   start;
   logic [N_CH-1:0]        en;
   logic [N_CH-1:0]        typ;
   logic [N_CH-1:0]        fifo_empty;
   logic [N_CH*DATA_W-1:0] fifo_data;
   logic [N_CH-1:0]        fifo_read_enable;
   logic [DATA_W-1:0]      data_out;
   logic                   data_valid;
   logic [CHID_W-1:0]      chid_out;
   logic                   busy;

   odu_chid_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W), .CHID_W(CHID_W)) dut (
      .clk(clk), .rst(rst), .start(start), .enable_chid(en), .type_chid(typ),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_enable(fifo_read_enable),
      .data_out(data_out), .data_valid(data_valid), .chid_out(chid_out), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mk_word(input int ch, input int idx);
      logic [DATA_W-1:0] w;
      w = '0;
      w[7:0]             = 8'(ch);
      w[15:8]            = 8'(idx);
      w[100 +: 16]       = 16'hA5C3 ^ 16'(ch * 257);
      w[200 +: 8]        = 8'(ch * 3 + idx);
      w[DATA_W-1 -: 8]   = ~8'(idx);
      return w;
   endfunction

   // Show-ahead FIFO model: head word is visible while non-empty, a strobe pops it at the edge.
   int   head  [N_CH];
   int   depth [N_CH];
   logic model_clr;

   always @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (model_clr) head[c] <= 0;
         else if (fifo_read_enable[c] && head[c] < depth[c]) head[c] <= head[c] + 1;
      end
   end

   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         fifo_empty[c]                 = (head[c] >= depth[c]);
         fifo_data[c*DATA_W +: DATA_W] = mk_word(c, head[c]);
      end
   end

   typedef struct { int ch; int idx; } out_t;
   int   exp_grant[$];
   out_t exp_out[$];
   int   exp_gap;
   int   chk_req, chk_kind;
   int   checks, errors;

   // Monitor: sole owner of checks/errors.
   int chk_ack = 0;
   int cyc = 0;
   int last_strobe = -1;
   int h1 = -1, h2 = -1;
   always @(negedge clk) begin
      int   cur;
      int   g;
      out_t o;
      cyc++;
      if (chk_req != chk_ack) begin
         chk_ack = chk_req;
         checks++;
         case (chk_kind)
            1: if (fifo_read_enable != '0 || data_out != '0 || data_valid || chid_out != '0 || busy) begin
                  errors++;
                  $display("FAIL reset_zero fre=%h dv=%0b chid=%0d busy=%0b data_nonzero=%0b want all 0",
                           fifo_read_enable, data_valid, chid_out, busy, data_out != '0);
               end
            2: if (fifo_read_enable != '0 || data_valid || busy) begin
                  errors++;
                  $display("FAIL quiet fre=%h dv=%0b busy=%0b want 0 0 0", fifo_read_enable, data_valid, busy);
               end
            default: begin
               errors++;
               $display("FAIL timeout pending grants=%0d outs=%0d busy=%0b want 0 0 0",
                        exp_grant.size(), exp_out.size(), busy);
            end
         endcase
      end
      if (!rst) begin
         last_strobe = -1;
         h1 = -1;
         h2 = -1;
      end else begin
         cur = -1;
         if (fifo_read_enable != '0) begin
            for (int c = 0; c < N_CH; c++) if (fifo_read_enable[c]) cur = c;
            checks++;
            if (!$onehot(fifo_read_enable)) begin
               errors++;
               $display("FAIL onehot fre=%h want one-hot", fifo_read_enable);
            end
            checks++;
            if (exp_grant.size() == 0) begin
               errors++;
               $display("FAIL extra_strobe got ch%0d want none", cur);
            end else begin
               g = exp_grant.pop_front();
               if (g != cur) begin
                  errors++;
                  $display("FAIL grant got ch%0d want ch%0d", cur, g);
               end
            end
            if (exp_gap != 0 && last_strobe >= 0) begin
               checks++;
               if (cyc - last_strobe != exp_gap) begin
                  errors++;
                  $display("FAIL strobe_gap got %0d want %0d", cyc - last_strobe, exp_gap);
               end
            end
            last_strobe = cyc;
         end
         if (data_valid) begin
            checks++;
            if (int'(chid_out) != h2) begin
               errors++;
               $display("FAIL latency chid=%0d want strobed ch %0d two cycles earlier", chid_out, h2);
            end
            checks++;
            if (exp_out.size() == 0) begin
               errors++;
               $display("FAIL extra_valid chid=%0d want no data_valid", chid_out);
            end else begin
               o = exp_out.pop_front();
               checks++;
               if (int'(chid_out) != o.ch || data_out != mk_word(o.ch, o.idx)) begin
                  errors++;
                  $display("FAIL out_word chid=%0d w[15:0]=%h want chid=%0d w[15:0]=%h",
                           chid_out, data_out[15:0], o.ch, mk_word(o.ch, o.idx) & 16'hFFFF);
               end
            end
         end
         h2 = h1;
         h1 = cur;
      end
   end

   task automatic post(input int kind);
      chk_kind = kind;
      chk_req  = chk_req + 1;
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
   endtask

   task automatic push_o(input int ch, input int idx);
      out_t o;
      o.ch  = ch;
      o.idx = idx;
      exp_out.push_back(o);
   endtask

   task automatic reset_env();
      rst       = 1'b0;
      start     = 1'b0;
      en        = '0;
      typ       = '0;
      exp_gap   = 0;
      model_clr = 1'b1;
      for (int c = 0; c < N_CH; c++) depth[c] = 0;
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b1;
      model_clr = 1'b0;
   endtask

   task automatic finish_test(input int max_cyc);
      int n;
      n = 0;
      while ((exp_grant.size() != 0 || exp_out.size() != 0) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      #1;
      start = 1'b0;
      if (exp_grant.size() != 0 || exp_out.size() != 0) begin
         post(3);
         exp_grant.delete();
         exp_out.delete();
      end
      n = 0;
      while (busy && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      repeat (2) @(posedge clk);
      #1;
      post(2);
      exp_gap = 0;
   endtask

   initial begin
      chk_req  = 0;
      chk_kind = 0;
      checks   = 0;
      errors   = 0;
      for (int c = 0; c < N_CH; c++) depth[c] = 0;
      reset_env();
      post(1);

      // Single channel: one strobe every other cycle, words in FIFO order.
      reset_env();
      depth[5] = 6;
      for (int k = 0; k < 6; k++) begin
         exp_grant.push_back(5);
         push_o(5, k);
      end
      exp_gap = 2;
      en[5]   = 1'b1;
      start   = 1'b1;
      finish_test(60);

      // All channels: 0..79 then wrap, back-to-back strobes.
      reset_env();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < N_CH; c++) begin
            exp_grant.push_back(c);
            push_o(c, r);
         end
      end
      for (int c = 0; c < N_CH; c++) depth[c] = 2;
      exp_gap = 1;
      en      = '1;
      start   = 1'b1;
      finish_test(400);

      // ptr parked at 71 by a lone ch70 read, then 10 and 70 compete.
      reset_env();
      depth[70] = 3;
      depth[10] = 2;
      exp_grant.push_back(70); push_o(70, 0);
      exp_grant.push_back(10); push_o(10, 0);
      exp_grant.push_back(70); push_o(70, 1);
      exp_grant.push_back(10); push_o(10, 1);
      exp_grant.push_back(70); push_o(70, 2);
      en[70] = 1'b1;
      start  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      en[10] = 1'b1;
      finish_test(60);

      // Start dropped with two reads in flight.
      reset_env();
      for (int c = 0; c < 4; c++) begin
         depth[c] = 5;
         en[c]    = 1'b1;
      end
      exp_grant.push_back(0); push_o(0, 0);
      exp_grant.push_back(1); push_o(1, 0);
      exp_gap = 1;
      start   = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      finish_test(30);

      // Reset one cycle after a strobe: pipeline contents discarded.
      reset_env();
      depth[7] = 3;
      en[7]    = 1'b1;
      exp_grant.push_back(7);
      start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      post(1);
      start = 1'b0;
      rst   = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      finish_test(10);

`ifdef ODU_SCHED_PRIO_EN
      // High-class ch60 wins every cycle it is not locked; low-class ch3 fills the gaps.
      reset_env();
      depth[3]  = 3;
      depth[60] = 3;
      typ[60]   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_grant.push_back(60); push_o(60, k);
         exp_grant.push_back(3);  push_o(3, k);
      end
      exp_gap = 1;
      en[3]   = 1'b1;
      en[60]  = 1'b1;
      start   = 1'b1;
      finish_test(60);
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1);
   end
endmodule
